// File: rtl/icache_if.sv
// CPU fetch port and main-memory line port of the instruction cache.
interface icache_if;
    logic         cpu_read;
    logic [31:0]  cpu_addr;
    logic [31:0]  cpu_rdata;
    logic         cpu_resp;
    logic         flush;
    logic         mem_read;
    logic [31:0]  mem_addr;
    logic [255:0] mem_rdata;
    logic         mem_resp;

    modport slave (
        input  cpu_read, cpu_addr, flush, mem_rdata, mem_resp,
        output cpu_rdata, cpu_resp, mem_read, mem_addr
    );
    modport master (
        output cpu_read, cpu_addr, flush, mem_rdata, mem_resp,
        input  cpu_rdata, cpu_resp, mem_read, mem_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped instruction cache, 256-bit lines, IDLE/TAG/FETCH controller.
// Define ICACHE_STATS_EN to add hit_count/miss_count outputs.
module icache #(
    parameter int SETS = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    icache_if.slave     bus
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count
`endif
);
    localparam int IW = $clog2(SETS);
    localparam int TW = 27 - IW;

    typedef enum logic [1:0] {IDLE, TAG, FETCH} state_t;

    state_t            state, state_nx;
    logic [31:2]       addr_q;
    logic [SETS-1:0]   valid;
    logic [7:0][31:0]  data_arr [SETS];
    logic [TW-1:0]     tag_arr  [SETS];

    logic [2:0]        off;
    logic [IW-1:0]     idx;
    logic [TW-1:0]     tag;
    logic              hit, fill;
    logic              resp, mrd;
    logic [31:0]       maddr;

    assign off  = addr_q[4:2];
    assign idx  = addr_q[5 +: IW];
    assign tag  = addr_q[31 -: TW];
    assign hit  = valid[idx] && (tag_arr[idx] == tag);
    assign fill = (state == FETCH) && bus.mem_resp;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            addr_q <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && bus.cpu_read) addr_q <= bus.cpu_addr[31:2];
        end
    end

    always_comb begin
        state_nx = state;
        resp     = 1'b0;
        mrd      = 1'b0;
        maddr    = '0;
        case (state)
            IDLE:  if (bus.cpu_read) state_nx = TAG;
            TAG: begin
                // A requester that gave up while we were away gets nothing.
                if (!bus.cpu_read) begin
                    state_nx = IDLE;
                end else if (hit) begin
                    resp     = 1'b1;
                    state_nx = IDLE;
                end else begin
                    state_nx = FETCH;
                end
            end
            FETCH: begin
                mrd   = 1'b1;
                maddr = {addr_q[31:5], 5'b0};
                if (bus.mem_resp) state_nx = TAG;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.cpu_resp  = resp;
    assign bus.cpu_rdata = data_arr[idx][off];
    assign bus.mem_read  = mrd;
    assign bus.mem_addr  = maddr;

    // Flush has priority so a line refilled in the flush cycle stays invalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      valid      <= '0;
        else if (bus.flush) valid   <= '0;
        else if (fill)   valid[idx] <= 1'b1;
    end

    always_ff @(posedge clk) begin
        if (fill) begin
            data_arr[idx] <= bus.mem_rdata;
            tag_arr[idx]  <= tag;
        end
    end

`ifdef ICACHE_STATS_EN
    logic fetched;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_count  <= '0;
            miss_count <= '0;
            fetched    <= 1'b0;
        end else begin
            if (state == IDLE && bus.cpu_read) fetched <= 1'b0;
            if (state == TAG && state_nx == FETCH) begin
                miss_count <= miss_count + 32'd1;
                fetched    <= 1'b1;
            end
            if (resp && !fetched) hit_count <= hit_count + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: vector table of reads plus hand-built flush,
// abandon and reset sequences; read data is checked through a scoreboard queue.
module tb_icache;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_if bus ();

    logic flush_a = 1'b0;
    logic flush_b = 1'b0;
    assign bus.flush = flush_a | flush_b;

`ifdef ICACHE_STATS_EN
    logic [31:0] hit_count, miss_count;
`endif

    icache #(.SETS(16)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
`ifdef ICACHE_STATS_EN
        ,
        .hit_count  (hit_count),
        .miss_count (miss_count)
`endif
    );

    int n_cmp = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];

    int mem_lat = 0;
    int wait_cnt = 0;
    int fetch_cnt = 0;
    bit flush_on_resp = 0;
    bit stray = 0;

    typedef struct {
        logic [31:0] addr;
        bit          hit;
        logic [31:0] maddr;
        logic [31:0] rdata;
        int          lat;
    } vec_t;
    vec_t tbl[8];

    function automatic logic [255:0] line_data(input logic [31:0] la);
        logic [255:0] d;
        for (int w = 0; w < 8; w++)
            d[w*32 +: 32] = 32'h1000 + 32'(w) + ((la ^ 32'h40) << 8);
        return d;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Memory model: answers after mem_lat full FETCH cycles; rdata is noise otherwise.
    always @(negedge clk) begin
        if (bus.mem_read && !bus.mem_resp) begin
            wait_cnt++;
            if (wait_cnt > mem_lat) begin
                bus.mem_resp  = 1'b1;
                bus.mem_rdata = line_data(bus.mem_addr);
                fetch_cnt++;
                if (flush_on_resp) begin
                    flush_b       = 1'b1;
                    flush_on_resp = 0;
                end
            end
        end else begin
            wait_cnt = 0;
            flush_b  = 1'b0;
            bus.mem_resp = stray;
            for (int w = 0; w < 8; w++) bus.mem_rdata[w*32 +: 32] = $urandom;
        end
    end

    // Scoreboard: every cpu_resp consumes one expected word.
    always @(negedge clk) begin
        if (rst_n && bus.cpu_resp) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL unexpected_resp: got %h want none", bus.cpu_rdata);
            end else begin
                check("rdata", bus.cpu_rdata, exp_q.pop_front());
            end
        end
    end

    task automatic do_read(input logic [31:0] a, input int exp_n, input bit exp_fetch,
                           input logic [31:0] maddr, input logic [31:0] rd,
                           input int lat, input string nm);
        int n = 0;
        bit seen = 0;
        logic [31:0] sa = '0;
        mem_lat = lat;
        @(posedge clk); #1;
        bus.cpu_read = 1'b1;
        bus.cpu_addr = a;
        exp_q.push_back(rd);
        do begin
            @(posedge clk); #1;
            n++;
            if (bus.mem_read && !seen) begin
                seen = 1;
                sa   = bus.mem_addr;
            end
        end while (!bus.cpu_resp && n < 200);
        if (!bus.cpu_resp && exp_q.size() > 0) void'(exp_q.pop_back());
        check({nm, " latency"}, n, exp_n);
        check({nm, " fetched"}, 32'(seen), 32'(exp_fetch));
        if (exp_fetch) check({nm, " mem_addr"}, sa, maddr);
        @(posedge clk); #1;
        bus.cpu_read = 1'b0;
    endtask

    task automatic rd_vec(input vec_t v, input string nm);
        do_read(v.addr, v.hit ? 1 : 3 + v.lat, !v.hit, v.maddr, v.rdata, v.lat, nm);
    endtask

    initial begin
        int fc;
        int k;
        tbl[0] = '{32'h0000_0044, 1'b0, 32'h0000_0040, 32'h0000_1001, 3};
        tbl[1] = '{32'h0000_0048, 1'b1, 32'h0,         32'h0000_1002, 0};
        tbl[2] = '{32'h0000_0240, 1'b0, 32'h0000_0240, 32'h0002_1000, 2};
        tbl[3] = '{32'h0000_0040, 1'b0, 32'h0000_0040, 32'h0000_1000, 0};
        tbl[4] = '{32'h0000_005C, 1'b1, 32'h0,         32'h0000_1007, 0};
        tbl[5] = '{32'h0000_009C, 1'b0, 32'h0000_0080, 32'h0000_D007, 1};
        tbl[6] = '{32'h0000_0084, 1'b1, 32'h0,         32'h0000_D001, 0};
        tbl[7] = '{32'h0000_025C, 1'b0, 32'h0000_0240, 32'h0002_1007, 2};

        bus.cpu_read = 1'b0;
        bus.cpu_addr = '0;
        bus.mem_resp = 1'b0;
        bus.mem_rdata = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset cpu_resp", 32'(bus.cpu_resp), 0);
        check("reset mem_read", 32'(bus.mem_read), 0);
        check("reset mem_addr", bus.mem_addr, 0);
`ifdef ICACHE_STATS_EN
        check("reset hit_count", hit_count, 0);
        check("reset miss_count", miss_count, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            rd_vec(tbl[i], $sformatf("vec%0d", i));
`ifdef ICACHE_STATS_EN
            if (i == 3) begin
                check("stats miss_count", miss_count, 3);
                check("stats hit_count", hit_count, 1);
            end
`endif
        end

        // Idle flush invalidates every line.
        do_read(32'h44, 6, 1, 32'h40, 32'h1001, 3, "refill");
        do_read(32'h44, 1, 0, 32'h0, 32'h1001, 0, "refill hit");
        @(posedge clk); #1 flush_a = 1'b1;
        @(posedge clk); #1 flush_a = 1'b0;
        do_read(32'h44, 5, 1, 32'h40, 32'h1001, 2, "post-flush");
        do_read(32'h84, 3, 1, 32'h80, 32'hD001, 0, "post-flush other");

        // Flush landing on the refill cycle forces a second fetch.
        fc = fetch_cnt;
        flush_on_resp = 1;
        do_read(32'h308, 7, 1, 32'h300, 32'h0003_5002, 1, "flush-on-fill");
        check("flush-on-fill fetches", fetch_cnt - fc, 2);
        do_read(32'h308, 1, 0, 32'h0, 32'h0003_5002, 0, "flush-on-fill hit");

        // Requester drops mid-FETCH: fill completes, no response.
        fc = fetch_cnt;
        mem_lat = 4;
        @(posedge clk); #1;
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 32'h104;
        repeat (3) @(posedge clk);
        #1 bus.cpu_read = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("abandon fetches", fetch_cnt - fc, 1);
        check("abandon idle mem_read", 32'(bus.mem_read), 0);
        check("abandon idle mem_addr", bus.mem_addr, 0);
        do_read(32'h104, 1, 0, 32'h0, 32'h0001_5001, 0, "abandon hit");

        // cpu_read gone by the TAG cycle: no fetch, no response.
        fc = fetch_cnt;
        @(posedge clk); #1;
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 32'h1E4;
        @(posedge clk); #1 bus.cpu_read = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("tag-drop fetches", fetch_cnt - fc, 0);
        check("tag-drop mem_read", 32'(bus.mem_read), 0);

        // Reset two cycles into FETCH.
        mem_lat = 20;
        @(posedge clk); #1;
        bus.cpu_read = 1'b1;
        bus.cpu_addr = 32'h1E4;
        k = 0;
        while (!bus.mem_read && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        check("pre-reset mem_read", 32'(bus.mem_read), 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("async reset mem_read", 32'(bus.mem_read), 0);
        check("async reset mem_addr", bus.mem_addr, 0);
        check("async reset cpu_resp", 32'(bus.cpu_resp), 0);
        bus.cpu_read = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
`ifdef ICACHE_STATS_EN
        check("post-reset miss_count", miss_count, 0);
`endif
        stray = 1;
        repeat (2) @(posedge clk);
        #1 stray = 0;
        check("stray mem_read", 32'(bus.mem_read), 0);
        do_read(32'h04, 4, 1, 32'h0, 32'h5001, 1, "post-reset line0");
        do_read(32'h1E4, 4, 1, 32'h1E0, 32'h0001_B001, 1, "post-reset refill");
        do_read(32'h48, 3, 1, 32'h40, 32'h1002, 0, "post-reset cold");

        repeat (3) @(posedge clk);
        check("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/icache.md
ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter SETS, default 16, number of direct-mapped 256-bit lines (power of two, 2..256).
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cpu_read  input  1  fetch request; held high by requester until cpu_resp.
REQ-005 SHALL have port cpu_addr  input  32  byte address of requested word; bits [1:0] ignored; held stable while cpu_read high.
REQ-006 SHALL have port cpu_rdata  output  32  requested word; valid only while cpu_resp high.
REQ-007 SHALL have port cpu_resp  output  1  one-cycle completion pulse.
REQ-008 SHALL have port flush  input  1  invalidate all lines.
REQ-009 SHALL have port mem_read  output  1  line read request to main memory.
REQ-010 SHALL have port mem_addr  output  32  line-aligned address, bits [4:0] = 0.
REQ-011 SHALL have port mem_rdata  input  256  returned line; word w at bits [32w+31:32w].
REQ-012 SHALL have port mem_resp  input  1  line valid; may be asserted combinationally in the same cycle as mem_read.

Function
REQ-013 SHALL split the latched address: offset = [4:2], index = next log2(SETS) bits, tag = remaining upper bits.
REQ-014 SHALL implement states IDLE, TAG, FETCH; reset state IDLE.
REQ-015 IDLE: cpu_read=1 SHALL latch cpu_addr and go TAG; otherwise stay in IDLE.
REQ-016 TAG, valid and tag match: SHALL assert cpu_resp with cpu_rdata = line word[offset] for one cycle, then go IDLE.
REQ-017 TAG, miss: SHALL go FETCH with no cpu_resp.
REQ-018 TAG, cpu_read already low: SHALL go IDLE with no cpu_resp and no fetch.
REQ-019 FETCH: SHALL hold mem_read=1 and mem_addr = {latched tag, index, 5'b0} until a cycle with mem_resp=1.
REQ-020 FETCH with mem_resp=1: SHALL write mem_rdata, tag and valid=1 into the indexed line and go TAG; mem_read SHALL drop the following cycle.
REQ-021 SHALL never sample mem_rdata when mem_resp=0.
REQ-022 Hit latency: cpu_resp SHALL be high in the cycle after cpu_read is first sampled high; minimum issue interval 2 cycles.
REQ-023 Miss latency: cpu_resp SHALL follow 1 cycle after the mem_resp cycle.
REQ-024 An in-progress FETCH SHALL complete even if cpu_read drops; the line is filled and REQ-018 applies in TAG.
REQ-025 flush=1 SHALL clear every valid bit at the clock edge in any state.
REQ-026 flush coinciding with a refill write SHALL win: the line ends invalid and the following TAG misses and refetches.
REQ-027 cpu_resp, mem_read SHALL be 0 outside TAG-hit and FETCH respectively; mem_addr SHALL be 0 in IDLE.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, cpu_resp=0, mem_read=0, mem_addr=0, all valid bits=0, independent of clk.
REQ-029 Reset during FETCH SHALL abandon the fill; a mem_resp arriving afterwards SHALL be ignored.
REQ-030 Data and tag arrays need not be reset.

Configuration
REQ-031 With ICACHE_STATS_EN defined, SHALL add outputs hit_count and miss_count (32 bits each, reset 0, wrap at 2^32).
REQ-032 miss_count SHALL increment on each TAG->FETCH transition; hit_count SHALL increment on each cpu_resp whose request did not pass through FETCH.
REQ-033 Without ICACHE_STATS_EN, those ports and counters SHALL not exist; all other behaviour identical.

Verification
REQ-034 Cold miss: reset, cpu_read addr 0x0000_0044 -> mem_read with mem_addr 0x0000_0040; mem_resp after 3 cycles with line word i = 0x1000+i -> cpu_resp, cpu_rdata 0x1001.
REQ-035 Hit: repeat read 0x0000_0048 -> cpu_resp next cycle, rdata 0x1002, mem_read stays 0.
REQ-036 Conflict (SETS=16): read 0x0000_0240 after 0x0000_0040 -> miss and refetch at 0x0000_0240; then 0x0000_0040 misses again.
REQ-037 Flush: after fill, pulse flush, read 0x0000_0044 -> miss; flush in the mem_resp cycle -> second fetch of the same line.
REQ-038 Reset mid-FETCH: rst_n low 2 cycles into FETCH -> mem_read 0 immediately, later read misses.
REQ-039 Stats (ICACHE_STATS_EN): sequence REQ-034..REQ-036 -> miss_count 3, hit_count 1.
